// File: rtl/stego_decode_ctrl_if.sv
// stego_decode_ctrl_if: command, pixel-memory, decoder and message-sink signals of the stego decode sequencer
interface stego_decode_ctrl_if #(parameter int ADDR_W = 17, parameter int LEN_W = 16);
  logic start;
  logic [5:0] mode_sw;
  logic [LEN_W-1:0] msg_len;
  logic pix_rd;
  logic [ADDR_W-1:0] pix_addr;
  logic pix_valid;
  logic [23:0] pix_data;
  logic dec_rst;
  logic dec_en;
  logic [23:0] dec_pix;
  logic [5:0] dec_mode;
  logic [23:0] dec_msg;
  logic [23:0] word_out;
  logic word_valid;
  logic word_ready;
  logic busy;
  logic done;
  logic err_mode;
  logic err_ovr;
  modport master (
    input start, mode_sw, msg_len, pix_valid, pix_data, dec_msg, word_ready,
    output pix_rd, pix_addr, dec_rst, dec_en, dec_pix, dec_mode, word_out, word_valid,
    busy, done, err_mode, err_ovr
  );
  modport slave (
    output start, mode_sw, msg_len, pix_valid, pix_data, dec_msg, word_ready,
    input pix_rd, pix_addr, dec_rst, dec_en, dec_pix, dec_mode, word_out, word_valid,
    busy, done, err_mode, err_ovr
  );
endinterface

// File: rtl/stego_decode_ctrl.sv
// stego_decode_ctrl: fetches stego pixels, feeds the LSB decoder one pixel per enable and
// forwards each completed 24-bit message word downstream over valid/ready.
module stego_decode_ctrl #(
  parameter int ADDR_W = 17,
  parameter int NUM_PIXELS = 76800,
  parameter int LEN_W = 16
) (
  input logic clk,
  input logic rst,
  stego_decode_ctrl_if.master bus
);
  typedef enum logic [2:0] {IDLE, CLR, RD, WAIT, FEED, CAPT, OUT, DONE} state_t;
  state_t state, nxt;
  logic [5:0] mode;
  logic [LEN_W-1:0] len, words_fed, words_out;
  logic [ADDR_W-1:0] addr;
  logic [4:0] pix_cnt, ppw;
  logic [23:0] pix, word;
  logic flush, ovr, err_mode, bad, go, pub, last, end_img;
  assign ppw = mode[0] ? 5'd4 : mode[1] ? 5'd8 : mode[2] ? 5'd24 :
               mode[3] ? 5'd6 : mode[4] ? 5'd12 : 5'd5;
  assign bad = bus.start && !$onehot(bus.mode_sw);
  assign go = bus.start && !bad && bus.msg_len != '0;
  // decoder publishes word N when the first pixel of word N+1 is fed
  assign pub = pix_cnt == 5'd0 && words_fed != '0;
  // last real pixel of the final word: follow with a zero flush pixel
  assign last = !flush && pix_cnt == ppw - 5'd1 && words_fed == len - LEN_W'(1);
  assign end_img = addr == ADDR_W'(NUM_PIXELS);
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    case (state)
      IDLE: nxt = go ? CLR : (bus.start && !bad) ? DONE : IDLE;
      CLR: nxt = RD;
      RD: nxt = end_img ? DONE : WAIT;
      WAIT: nxt = bus.pix_valid ? FEED : WAIT;
      FEED: nxt = pub ? CAPT : last ? FEED : RD;
      CAPT: nxt = OUT;
      OUT: nxt = !bus.word_ready ? OUT : (words_out + LEN_W'(1) == len) ? DONE : RD;
      default: nxt = IDLE;
    endcase
  end
  always_comb begin
    bus.pix_rd = state == RD && !end_img;
    bus.dec_rst = state == CLR;
    bus.dec_en = state == FEED;
    bus.word_valid = state == OUT;
    bus.busy = state inside {CLR, RD, WAIT, FEED, CAPT, OUT};
    bus.done = state == DONE;
    bus.err_ovr = state == DONE && ovr;
    bus.err_mode = err_mode;
    bus.pix_addr = addr;
    bus.dec_pix = pix;
    bus.dec_mode = mode;
    bus.word_out = word;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      mode <= '0;
      len <= '0;
      words_fed <= '0;
      words_out <= '0;
      addr <= '0;
      pix_cnt <= '0;
      pix <= '0;
      word <= '0;
      flush <= 1'b0;
      ovr <= 1'b0;
      err_mode <= 1'b0;
    end else begin
      err_mode <= state == IDLE && bad;
      if (state == IDLE) ovr <= 1'b0;
      if (state == IDLE && go) begin
        mode <= bus.mode_sw;
        len <= bus.msg_len;
      end
      if (state == CLR) begin
        addr <= '0;
        pix_cnt <= '0;
        words_fed <= '0;
        words_out <= '0;
        flush <= 1'b0;
      end
      if (state == RD && end_img) ovr <= 1'b1;
      if (state == WAIT && bus.pix_valid) pix <= bus.pix_data;
      if (state == FEED) begin
        addr <= flush ? addr : addr + ADDR_W'(1);
        pix_cnt <= pix_cnt == ppw - 5'd1 ? 5'd0 : pix_cnt + 5'd1;
        words_fed <= pix_cnt == ppw - 5'd1 ? words_fed + LEN_W'(1) : words_fed;
        flush <= last;
        if (last) pix <= '0;
      end
      if (state == CAPT) word <= bus.dec_msg;
      if (state == OUT && bus.word_ready) words_out <= words_out + LEN_W'(1);
    end
endmodule

// File: tb/tb_stego_decode_ctrl.sv
// tb_stego_decode_ctrl: random and directed runs against a word-level model of the decode sequence,
// with a memory responder, a behavioural LSB decoder and a randomly stalling message sink.
module tb_stego_decode_ctrl;
  localparam int NP = 30;
  localparam int AW = 17;
  localparam int LW = 16;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  stego_decode_ctrl_if #(.ADDR_W(AW), .LEN_W(LW)) bus ();
  stego_decode_ctrl #(.ADDR_W(AW), .NUM_PIXELS(NP), .LEN_W(LW)) dut (.clk(clk), .rst(rst), .bus(bus));
  logic [23:0] mem [0:NP-1];
  logic [23:0] exp_word [0:31];
  logic [23:0] first_word;
  logic [5:0] exp_mode;
  bit exp_ovr;
  bit chk_en = 1'b1;
  int exp_reads, exp_nen, exp_nwords, stall_n, run_id;
  int n_rd, n_en, n_rst, n_acc, n_done, cyc, last_acc;
  int vectors = 0;
  int miscompares = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, expv, cyc);
    end
  endtask
  function automatic int bpp(input logic [5:0] m);
    case (m)
      6'd1: return 6;
      6'd2: return 3;
      6'd4: return 1;
      6'd8: return 4;
      6'd16: return 2;
      6'd32: return 5;
      default: return 0;
    endcase
  endfunction
  function automatic logic [23:0] fold(input int k, input int p, input int b);
    logic [23:0] w;
    w = '0;
    for (int j = 0; j < p; j++) w = (w << b) | (mem[k*p+j] & ((24'd1 << b) - 24'd1));
    return w;
  endfunction
  function automatic logic any_out();
    return |{bus.pix_rd, bus.pix_addr, bus.dec_rst, bus.dec_en, bus.dec_pix, bus.dec_mode,
             bus.word_out, bus.word_valid, bus.busy, bus.done, bus.err_mode, bus.err_ovr};
  endfunction
  // image memory: one outstanding read, latency 1..4, stray valid pulses when idle
  initial begin
    int cnt, a;
    cnt = 0;
    a = 0;
    bus.pix_valid = 1'b0;
    bus.pix_data = '0;
    forever begin
      @(negedge clk);
      bus.pix_valid = 1'b0;
      if (rst) cnt = 0;
      else if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          bus.pix_valid = 1'b1;
          bus.pix_data = (a < NP) ? mem[a] : 24'hDEAD00;
        end
      end else if (bus.pix_rd) begin
        a = int'(bus.pix_addr);
        cnt = $urandom_range(1, 4);
      end else if ($urandom_range(0, 9) == 0) begin
        bus.pix_valid = 1'b1;
        bus.pix_data = 24'($urandom);
      end
    end
  end
  // LSB decoder: packs b low bits per pixel, publishes a word when the next word's first pixel arrives
  initial begin
    int cnt, b;
    logic [23:0] acc;
    cnt = 0;
    acc = '0;
    bus.dec_msg = '0;
    forever begin
      @(negedge clk);
      b = bpp(bus.dec_mode);
      if (rst || bus.dec_rst) begin
        acc = '0;
        cnt = 0;
        bus.dec_msg = '0;
      end else if (bus.dec_en && b != 0) begin
        if (cnt == (24 + b - 1) / b) begin
          bus.dec_msg = acc;
          acc = '0;
          cnt = 0;
        end
        acc = (acc << b) | (bus.dec_pix & ((24'd1 << b) - 24'd1));
        cnt++;
      end
    end
  end
  // message sink: random ready, optional long stall on the first word of a run
  initial begin
    int hold, seen;
    bit used;
    hold = 0;
    seen = -1;
    used = 1'b0;
    bus.word_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (seen != run_id) begin
        seen = run_id;
        used = 1'b0;
        hold = 0;
      end
      if (hold > 0) begin
        hold--;
        bus.word_ready = 1'b0;
      end else if (bus.word_valid && !used && stall_n > 0) begin
        used = 1'b1;
        hold = stall_n - 1;
        bus.word_ready = 1'b0;
      end else bus.word_ready = $urandom_range(0, 3) != 0;
    end
  end
  // per-cycle comparison against the model
  initial begin
    cyc = 0;
    forever begin
      @(negedge clk);
      #1;
      cyc++;
      if (chk_en) begin
        if (bus.pix_rd) begin
          chk("rd_addr", 32'(bus.pix_addr), n_rd);
          n_rd++;
        end
        if (bus.dec_en) begin
          chk("dec_pix", 32'(bus.dec_pix), n_en < exp_reads ? 32'(mem[n_en]) : 32'd0);
          n_en++;
        end
        if (bus.dec_rst) n_rst++;
        if (bus.pix_rd || bus.dec_en || bus.dec_rst || bus.word_valid) begin
          chk("busy_run", 32'(bus.busy), 1);
          chk("dec_mode", 32'(bus.dec_mode), 32'(exp_mode));
        end
        if (bus.word_valid) begin
          chk("stall_quiet", 32'(bus.pix_rd | bus.dec_en), 0);
          chk("word_out", 32'(bus.word_out), n_acc < 32 ? 32'(exp_word[n_acc]) : 32'hFFFFFFFF);
          if (bus.word_ready) begin
            if (n_acc == 0) first_word = bus.word_out;
            n_acc++;
            last_acc = cyc;
          end
        end
        if (bus.done) begin
          n_done++;
          chk("err_ovr", 32'(bus.err_ovr), 32'(exp_ovr));
          chk("busy_done", 32'(bus.busy), 0);
          if (exp_nwords > 0 && !exp_ovr) chk("done_lat", cyc - last_acc, 1);
        end else chk("err_ovr_nodone", 32'(bus.err_ovr), 0);
      end
    end
  end
  task automatic begin_run(input logic [5:0] m, input int len, input int stall, input bit fixed);
    int b, p, tot;
    if (!fixed) for (int i = 0; i < NP; i++) mem[i] = 24'($urandom);
    b = bpp(m);
    p = (24 + b - 1) / b;
    tot = len * p;
    exp_mode = m;
    stall_n = stall;
    if (tot <= NP) begin
      exp_reads = tot;
      exp_nen = tot + 1;
      exp_nwords = len;
      exp_ovr = 1'b0;
    end else begin
      exp_reads = NP;
      exp_nen = NP;
      exp_nwords = (NP - 1) / p;
      exp_ovr = 1'b1;
    end
    for (int k = 0; k < 32; k++) begin
      exp_word[k] = '0;
      if (k < exp_nwords) exp_word[k] = fold(k, p, b);
    end
    n_rd = 0;
    n_en = 0;
    n_rst = 0;
    n_acc = 0;
    n_done = 0;
    last_acc = -100;
    first_word = '0;
    run_id++;
    @(negedge clk);
    bus.start = 1'b1;
    bus.mode_sw = m;
    bus.msg_len = LW'(len);
    @(negedge clk);
    bus.start = 1'b0;
    bus.mode_sw = 6'($urandom);
    bus.msg_len = LW'($urandom);
  endtask
  task automatic end_run(input int lit_rd, input int lit_en, input int lit_nw);
    int t;
    t = 0;
    while (n_done == 0 && t < 4000) begin
      @(negedge clk);
      t++;
    end
    chk("run_done", n_done, 1);
    @(negedge clk);
    #2;
    chk("n_rd", n_rd, exp_reads);
    chk("n_en", n_en, exp_nen);
    chk("n_words", n_acc, exp_nwords);
    chk("n_dec_rst", n_rst, 1);
    chk("idle_busy", 32'(bus.busy), 0);
    chk("done_pulse", 32'(bus.done), 0);
    if (lit_rd >= 0) chk("lit_rd", n_rd, lit_rd);
    if (lit_en >= 0) chk("lit_en", n_en, lit_en);
    if (lit_nw >= 0) chk("lit_words", n_acc, lit_nw);
  endtask
  task automatic start_only(input logic [5:0] m, input int len, input bit want_err, input bit want_done);
    n_rd = 0;
    n_done = 0;
    exp_reads = 0;
    exp_nwords = 0;
    exp_ovr = 1'b0;
    @(negedge clk);
    bus.start = 1'b1;
    bus.mode_sw = m;
    bus.msg_len = LW'(len);
    @(negedge clk);
    bus.start = 1'b0;
    #2;
    chk("err_mode_pulse", 32'(bus.err_mode), 32'(want_err));
    chk("done_only", 32'(bus.done), 32'(want_done));
    chk("busy_start", 32'(bus.busy), 0);
    @(negedge clk);
    #2;
    chk("err_mode_end", 32'(bus.err_mode), 0);
    chk("done_end", 32'(bus.done), 0);
    repeat (6) @(negedge clk);
    chk("no_reads", n_rd, 0);
    chk("busy_after", 32'(bus.busy), 0);
  endtask
  initial begin
    logic [5:0] m;
    bus.start = 1'b0;
    bus.mode_sw = '0;
    bus.msg_len = '0;
    stall_n = 0;
    run_id = 0;
    exp_mode = '0;
    for (int i = 0; i < NP; i++) mem[i] = 24'($urandom);
    @(negedge clk);
    #1;
    chk("reset_state", 32'(any_out()), 0);
    @(negedge clk);
    rst = 1'b0;
    mem[0] = 24'h55AA2A;
    mem[1] = 24'h55AA15;
    mem[2] = 24'h55AA3F;
    mem[3] = 24'h55AA01;
    begin_run(6'd1, 1, 0, 1'b1);
    end_run(4, 5, 1);
    chk("lit_word", 32'(first_word), 32'h00A95FC1);
    begin_run(6'd1, 2, 0, 1'b0);
    end_run(8, 9, 2);
    begin_run(6'd4, 1, 0, 1'b0);
    end_run(24, 25, 1);
    begin_run(6'd32, 3, 5, 1'b0);
    end_run(15, 16, 3);
    start_only(6'b000011, 2, 1'b1, 1'b0);
    start_only(6'd8, 0, 1'b0, 1'b1);
    begin_run(6'd4, 2, 0, 1'b0);
    end_run(30, 30, 1);
    begin_run(6'd8, 5, 0, 1'b0);
    end_run(30, 31, 5);
    for (int r = 0; r < 4; r++) begin
      m = 6'(1 << $urandom_range(0, 5));
      begin_run(m, $urandom_range(1, 6), 0, 1'b0);
      repeat ($urandom_range(3, 60)) @(negedge clk);
      chk_en = 1'b0;
      rst = 1'b1;
      #1;
      chk("rst_async", 32'(any_out()), 0);
      @(negedge clk);
      rst = 1'b0;
      repeat (6) @(negedge clk);
      chk_en = 1'b1;
      m = 6'(1 << $urandom_range(0, 5));
      begin_run(m, $urandom_range(1, 6), 0, 1'b0);
      end_run(-1, -1, -1);
    end
    for (int r = 0; r < 25; r++) begin
      m = 6'(1 << $urandom_range(0, 5));
      begin_run(m, $urandom_range(1, 8), ($urandom_range(0, 1) != 0) ? $urandom_range(1, 6) : 0, 1'b0);
      end_run(-1, -1, -1);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
